// File: rtl/btn_led_arbiter.sv
// btn_led_arbiter: debounces two active-low buttons and round-robin grants the LED bank
// to one requester at a time for a fixed hold period.
module btn_led_arbiter #(
   parameter int unsigned DEBOUNCE_CYCLES = 270000,
   parameter int unsigned HOLD_CYCLES     = 13500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn1,
   input  logic       btn2,
   output logic [5:0] led,
   output logic [1:0] grant,
   output logic       busy
);
   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, G1, G2} state_t;
   state_t state_q, state_d;
   logic [1:0] s1_q, s2_q, deb_q, deb_d, ev_q, ev_d, pend_q, pend_d, req, enter;
   logic [DW-1:0] cnt_q [2];
   logic [DW-1:0] cnt_d [2];
   logic [HW-1:0] hold_q, hold_d;
   logic last2_q, last2_d, hold_end, pick1;
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         deb_d[i] = deb_q[i] ^ ((s2_q[i] != deb_q[i]) && (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)));
         ev_d[i]  = deb_q[i] & ~deb_d[i];
         cnt_d[i] = ((s2_q[i] != deb_q[i]) && (deb_d[i] == deb_q[i])) ? cnt_q[i] + DW'(1) : '0;
      end
      req      = pend_q | ev_q;
      hold_end = hold_q == HW'(HOLD_CYCLES - 1);
      // last2_q set means btn2 was served last, so btn1 wins a tie
      pick1    = req[0] & (~req[1] | last2_q);
      state_d  = state_q == G1 ? (hold_end ? (req[1] ? G2 : IDLE) : G1) :
                 state_q == G2 ? (hold_end ? (req[0] ? G1 : IDLE) : G2) :
                 (|req ? (pick1 ? G1 : G2) : IDLE);
      enter    = {state_d == G2 && state_q != G2, state_d == G1 && state_q != G1};
      // an owner's own press during its grant is dropped rather than latched
      pend_d   = (pend_q | (ev_q & {state_q != G2, state_q != G1})) & ~enter;
      last2_d  = enter[1] | (last2_q & ~enter[0]);
      hold_d   = (state_d == state_q && state_q != IDLE) ? hold_q + HW'(1) : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= '1;
         s2_q    <= '1;
         deb_q   <= '1;
         ev_q    <= '0;
         pend_q  <= '0;
         cnt_q   <= '{default: '0};
         state_q <= IDLE;
         hold_q  <= '0;
         last2_q <= 1'b1;
         led     <= '1;
         grant   <= '0;
         busy    <= 1'b0;
      end else begin
         s1_q    <= {btn2, btn1};
         s2_q    <= s1_q;
         deb_q   <= deb_d;
         ev_q    <= ev_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         hold_q  <= hold_d;
         last2_q <= last2_d;
         led     <= state_d == G1 ? 6'b111000 : state_d == G2 ? 6'b000111 : 6'b111111;
         grant   <= {state_d == G2, state_d == G1};
         busy    <= state_d != IDLE;
      end
   end
endmodule

// File: tb/tb_btn_led_arbiter.sv
// tb_btn_led_arbiter: segment table of per-cycle stimulus with expected grant,
// expectations queued on drive and compared after each clock edge.
module tb_btn_led_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn1 = 1'b0;
   logic btn2 = 1'b0;
   logic [5:0] led;
   logic [1:0] grant;
   logic busy;
   int n_checks = 0;
   int n_fail = 0;
   typedef struct {
      logic r;
      logic b1;
      logic b2;
      int n;
      logic [1:0] g;
   } seg_t;
   typedef struct {
      logic [5:0] led;
      logic [1:0] grant;
      logic busy;
      string name;
   } exp_t;
   seg_t segs[$];
   exp_t exp_q[$];

   btn_led_arbiter #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10)) dut (
      .clk(clk), .rst(rst), .btn1(btn1), .btn2(btn2),
      .led(led), .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] led_of(input logic [1:0] g);
      return g == 2'b01 ? 6'b111000 : g == 2'b10 ? 6'b000111 : 6'b111111;
   endfunction

   task automatic add(input string nm, input logic r, input logic b1, input logic b2,
                      input int n, input logic [1:0] g);
      segs.push_back('{r, b1, b2, n, g});
      for (int k = 0; k < n; k++) exp_q.push_back('{led_of(g), g, |g, nm});
   endtask

   task automatic check(input exp_t e);
      n_checks += 3;
      if (grant !== e.grant) begin
         n_fail++;
         $display("FAIL %s grant: got %b expected %b at %0t", e.name, grant, e.grant, $time);
      end
      if (led !== e.led) begin
         n_fail++;
         $display("FAIL %s led: got %b expected %b at %0t", e.name, led, e.led, $time);
      end
      if (busy !== e.busy) begin
         n_fail++;
         $display("FAIL %s busy: got %b expected %b at %0t", e.name, busy, e.busy, $time);
      end
   endtask

   initial begin
      add("reset", 1, 0, 0, 3, 2'b00);
      add("tie_debounce", 0, 0, 0, 6, 2'b00);
      add("tie_g1", 0, 0, 0, 10, 2'b01);
      add("tie_handoff_g2", 0, 0, 0, 10, 2'b10);
      add("tie_idle", 0, 1, 1, 8, 2'b00);
      add("single_debounce", 0, 0, 1, 6, 2'b00);
      add("single_g1", 0, 0, 1, 10, 2'b01);
      add("single_idle", 0, 1, 1, 8, 2'b00);
      add("glitch_low", 0, 1, 0, 3, 2'b00);
      add("glitch_high", 0, 1, 1, 6, 2'b00);
      add("tie2_debounce", 0, 0, 0, 6, 2'b00);
      add("tie2_g2_first", 0, 0, 0, 10, 2'b10);
      add("tie2_g1_next", 0, 0, 0, 10, 2'b01);
      add("tie2_idle", 0, 1, 1, 8, 2'b00);
      add("repress_press", 0, 0, 1, 4, 2'b00);
      add("repress_release", 0, 1, 1, 2, 2'b00);
      add("repress_release_g1", 0, 1, 1, 2, 2'b01);
      add("repress_again_g1", 0, 0, 1, 8, 2'b01);
      add("repress_dropped", 0, 0, 1, 6, 2'b00);
      add("repress_idle", 0, 1, 1, 8, 2'b00);
      add("rstmid_b2", 0, 1, 0, 2, 2'b00);
      add("rstmid_both", 0, 0, 0, 4, 2'b00);
      add("rstmid_g2", 0, 0, 0, 6, 2'b10);
      add("rstmid_rst", 1, 1, 1, 1, 2'b00);
      add("rstmid_after", 0, 1, 1, 15, 2'b00);
      foreach (segs[s]) begin
         for (int k = 0; k < segs[s].n; k++) begin
            rst = segs[s].r;
            btn1 = segs[s].b1;
            btn2 = segs[s].b2;
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL scoreboard_empty: got 0 entries expected at least 1");
            end else begin
               check(exp_q.pop_front());
            end
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/btn_led_arbiter.md
Name: btn_led_arbiter

Overview:
Shares the 6-LED bank between the two on-board push-button requesters. Each raw button is synchronised and debounced, and each press becomes a one-cycle request event. A round-robin arbiter grants the LED bank to one requester for a fixed hold time, and the owner's pattern is driven onto the LEDs. The block sits directly under top, between the btn1/btn2 pins and the led[5:0] pins.

Parameters:
DEBOUNCE_CYCLES, 270000, consecutive cycles a synchronised button level must differ from the debounced level before it is accepted (10 ms at 27 MHz)
HOLD_CYCLES, 13500000, cycles a grant is held (0.5 s at 27 MHz)

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
btn1  input  1  raw button 1, active-low (0 = pressed), asynchronous to clk
btn2  input  1  raw button 2, active-low, asynchronous to clk
led  output  6  LED bank, active-low (1 = off)
grant  output  2  one-hot owner; bit0 = btn1, bit1 = btn2; 00 = none
busy  output  1  high while any grant is active

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - led = 6'b111111 (all off), grant = 2'b00, busy = 0.
  - Pending flags = 0; debounced levels = 1 (released); all counters = 0.
  - Round-robin pointer = "last served = btn2", so btn1 wins the first tie.
- rst asserted mid-grant or mid-debounce returns every register to its reset value on the next edge. No request survives reset.
- Synchroniser: two flip-flops per button. The raw level reaches the debouncer 2 cycles late.
- Debouncer (per button):
  - The counter increments while the synced level differs from the debounced level. It clears to 0 on any cycle where the two are equal.
  - When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles causes no change.
- Press event: a one-cycle pulse when the debounced level goes 1->0. Release (0->1) produces no event. Holding a button produces exactly one event.
- Pending flags:
  - pendX sets on a press event of requester X.
  - pendX clears on the cycle grant X is issued.
  - A press event from the current owner during its own grant is dropped, not latched.
- FSM states: IDLE, G1, G2.
  - IDLE: if any pending or event, go to the winner's state next cycle. grant/led/busy update on that same edge, so latency is 1 cycle from the event to grant.
  - Tie (both requesting in the same cycle): the requester not last served wins. The loser stays pending.
  - G1 / G2: the hold counter starts at 0 on entry and increments each cycle.
  - At HOLD_CYCLES-1, the next state is the other requester's grant if it is pending (direct handoff, no IDLE cycle, busy stays 1). Otherwise the next state is IDLE.
  - The last-served pointer updates on grant entry.
  - A grant lasts exactly HOLD_CYCLES cycles.
- Outputs (all registered):
  - G1: led = 6'b111000 (led[2:0] lit).
  - G2: led = 6'b000111 (led[5:3] lit).
  - IDLE: led = 6'b111111.
  - grant is one-hot per state. busy = |grant.
- Simultaneous events:
  - Both pressed in IDLE: the round-robin winner is granted and the other is pending.
  - Non-owner pressed on the last grant cycle: it is latched and handed off next cycle.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.)
- Reset: assert rst 3 cycles with btn1=btn2=0 -> led=6'b111111, grant=00, busy=0 throughout and on the first cycle after release. No grant until debounce completes after rst drops.
- Single press: btn1 1->0 held -> event 6 cycles later (2 sync + 4). grant=01 and led=6'b111000 on the next cycle, held 10 cycles, then grant=00 and led=6'b111111.
- Glitch reject: btn2 low for 3 cycles then high -> no event, grant stays 00.
- Tie after reset: both buttons drop on the same cycle -> grant=01 for 10 cycles, then grant=10 on the immediately following cycle for 10 cycles (busy never drops), then IDLE. Repeat the tie -> btn2 wins first.
- Owner re-press: during a G1 grant, release and re-press btn1 -> press dropped. The grant ends after 10 cycles and returns to IDLE with no second G1.
- Reset mid-grant: assert rst at hold count 5 of G2 with btn1 pending -> next cycle grant=00, led=6'b111111, pending cleared. No grant follows while the buttons stay high.
